roi_axis_fifo: RTL and testbench

Output buffer placed directly downstream of the ROI crop stage. It accepts the cropped pixel stream, which has no backpressure (tdata/tvalid/tlast only), and re-emits it as a full AXI-Stream master with tready. When the consumer stalls long enough to fill the buffer, the block drops whole frame tails but always delivers a tlast, so frame boundaries survive downstream. Overflow is reported through a sticky flag and a dropped-beat counter.

---
 rtl/roi_axis_fifo.sv | 149 ++++++++++++++
 tb/tb_roi_axis_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_axis_fifo.sv
// Output FIFO behind the ROI crop stage: turns a no-backpressure pixel stream into
// an AXI-Stream master, dropping frame tails on overflow while still closing every frame.
module roi_axis_fifo #(
    parameter int BIT_D = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [BIT_D-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    output logic [BIT_D-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    output logic             m_tlast_o,
    input  logic             m_tready_i,
    output logic             ovf_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_PASS, ST_DROP, ST_CLOSE} st_t;

    st_t              st_q, st_d;
    logic [BIT_D:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [BIT_D-1:0] last_data_q, last_data_d;
    logic             tail_drop_q, tail_drop_d;
    logic             ovf_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             push, pop, space, drop;
    logic [BIT_D:0]   push_data;
    logic [BIT_D:0]   head;

    assign head       = mem[rd_ptr_q];
    assign m_tvalid_o = (count_q != '0);
    assign m_tdata_o  = m_tvalid_o ? head[BIT_D-1:0] : '0;
    assign m_tlast_o  = m_tvalid_o & head[BIT_D];
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_cnt_q;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        pop         = m_tvalid_o & m_tready_i;
        space       = (count_q != FULL) | pop;
        push        = 1'b0;
        drop        = 1'b0;
        push_data   = {s_tlast_i, s_tdata_i};
        st_d        = st_q;
        last_data_d = last_data_q;
        tail_drop_d = tail_drop_q;

        case (st_q)
            ST_PASS: begin
                if (s_tvalid_i) begin
                    if (space) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                        if (s_tlast_i) begin
                            last_data_d = s_tdata_i;
                            tail_drop_d = 1'b0;
                            st_d        = ST_CLOSE;
                        end else begin
                            st_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_tvalid_i) begin
                    if (s_tlast_i && space) begin
                        push = 1'b1;
                        st_d = ST_PASS;
                    end else begin
                        drop = 1'b1;
                        if (s_tlast_i) begin
                            last_data_d = s_tdata_i;
                            tail_drop_d = 1'b0;
                            st_d        = ST_CLOSE;
                        end
                    end
                end
            end
            ST_CLOSE: begin
                // A newer tlast replaces the owed one; plain beats mark a started-then-lost frame.
                if (s_tvalid_i) begin
                    drop = 1'b1;
                    if (s_tlast_i) begin
                        last_data_d = s_tdata_i;
                        tail_drop_d = 1'b0;
                    end else begin
                        tail_drop_d = 1'b1;
                    end
                end
                if (space) begin
                    push      = 1'b1;
                    push_data = {1'b1, last_data_q};
                    if (s_tvalid_i && s_tlast_i) begin
                        st_d = ST_CLOSE;
                    end else begin
                        st_d        = (tail_drop_q || s_tvalid_i) ? ST_DROP : ST_PASS;
                        tail_drop_d = 1'b0;
                    end
                end
            end
            default: st_d = ST_PASS;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q        <= ST_PASS;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            tail_drop_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            st_q        <= st_d;
            last_data_q <= last_data_d;
            tail_drop_q <= tail_drop_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: storage has no reset; count/valid gating makes stale contents unobservable.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_roi_axis_fifo.sv
// Bench for roi_axis_fifo: directed frame scenarios plus random traffic against a
// queue-based model of the buffer/drop/close behaviour.
module tb_roi_axis_fifo;

    localparam int BIT_D = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic [BIT_D-1:0] s_tdata_i = '0;
    logic             s_tvalid_i = 1'b0;
    logic             s_tlast_i = 1'b0;
    logic [BIT_D-1:0] m_tdata_o;
    logic             m_tvalid_o;
    logic             m_tlast_o;
    logic             m_tready_i = 1'b0;
    logic             ovf_o;
    logic [CNT_W-1:0] drop_cnt_o;

    int checks = 0;
    int failures = 0;

    roi_axis_fifo #(.BIT_D(BIT_D), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tlast_o  (m_tlast_o),
        .m_tready_i (m_tready_i),
        .ovf_o      (ovf_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: buffered beats, an owed closing beat, and whether we are skipping a frame.
    logic [BIT_D:0]   mq[$];
    bit               m_owe;
    logic [BIT_D-1:0] m_owe_data;
    bit               m_skip;
    bit               m_lost_after;
    bit               m_ovf;
    int               m_cnt;
    logic [BIT_D:0]   got[$];
    logic [BIT_D:0]   exp_q[$];

    task automatic model_reset();
        mq.delete();
        m_owe = 0; m_owe_data = '0; m_skip = 0; m_lost_after = 0;
        m_ovf = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit l, input logic [BIT_D-1:0] d, input bit r);
        bit pop, room, lost;
        pop  = (mq.size() > 0) && r;
        room = (mq.size() < DEPTH) || pop;
        lost = 0;
        if (pop) void'(mq.pop_front());
        if (m_owe) begin
            if (room) mq.push_back({1'b1, m_owe_data});
            if (v) begin
                lost = 1;
                if (l) begin m_owe_data = d; m_lost_after = 0; end
                else m_lost_after = 1;
            end
            if (room && !(v && l)) begin
                m_owe = 0;
                m_skip = m_lost_after;
                m_lost_after = 0;
            end
        end else if (m_skip) begin
            if (v) begin
                if (l && room) begin
                    mq.push_back({1'b1, d});
                    m_skip = 0;
                end else begin
                    lost = 1;
                    if (l) begin m_owe = 1; m_owe_data = d; m_lost_after = 0; m_skip = 0; end
                end
            end
        end else if (v) begin
            if (room) mq.push_back({l, d});
            else begin
                lost = 1;
                if (l) begin m_owe = 1; m_owe_data = d; m_lost_after = 0; end
                else m_skip = 1;
            end
        end
        if (lost) begin
            m_ovf = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    // One clock: drive inputs, advance the model, compare outputs 1 time unit after the edge.
    task automatic step(input bit v, input bit l, input logic [BIT_D-1:0] d, input bit r);
        logic             exp_v, exp_l;
        logic [BIT_D-1:0] exp_d;
        s_tvalid_i = v; s_tlast_i = l; s_tdata_i = d; m_tready_i = r;
        if (m_tvalid_o && r) got.push_back({m_tlast_o, m_tdata_o});
        model_step(v, l, d, r);
        @(posedge clk_i); #1;
        exp_v = (mq.size() != 0);
        exp_d = exp_v ? mq[0][BIT_D-1:0] : '0;
        exp_l = exp_v ? mq[0][BIT_D] : 1'b0;
        checks += 5;
        if (m_tvalid_o !== exp_v) begin failures++; $display("FAIL tvalid t=%0t got=%0b exp=%0b", $time, m_tvalid_o, exp_v); end
        if (m_tdata_o !== exp_d) begin failures++; $display("FAIL tdata t=%0t got=%h exp=%h", $time, m_tdata_o, exp_d); end
        if (m_tlast_o !== exp_l) begin failures++; $display("FAIL tlast t=%0t got=%0b exp=%0b", $time, m_tlast_o, exp_l); end
        if (ovf_o !== m_ovf) begin failures++; $display("FAIL ovf t=%0t got=%0b exp=%0b", $time, ovf_o, m_ovf); end
        if (drop_cnt_o !== CNT_W'(m_cnt)) begin failures++; $display("FAIL drop_cnt t=%0t got=%0d exp=%0d", $time, drop_cnt_o, m_cnt); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    // Reset with a live input beat present; it must be ignored and not counted.
    task automatic test_reset();
        rst_n_i = 1'b0;
        s_tvalid_i = 1'b1; s_tlast_i = 1'b0; s_tdata_i = 8'h5A; m_tready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        s_tvalid_i = 1'b0;
        model_reset();
        got.delete();
        checks++;
        if ({m_tvalid_o, m_tdata_o, m_tlast_o, ovf_o, drop_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%0b d=%h l=%0b ovf=%0b cnt=%0d exp all zero",
                     m_tvalid_o, m_tdata_o, m_tlast_o, ovf_o, drop_cnt_o);
        end
    endtask

    task automatic test_passthrough();
        test_reset();
        for (int i = 0; i < 6; i++) step(1'b1, i == 5, 8'h10 + 8'(i), 1'b1);
        idle(2);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 8'h10 + 8'(i)});
        checks++;
        if (got != exp_q) begin failures++; $display("FAIL passthrough_seq got=%p exp=%p", got, exp_q); end
        checks++;
        if (ovf_o !== 1'b0 || drop_cnt_o !== '0) begin
            failures++; $display("FAIL passthrough_nodrop got ovf=%0b cnt=%0d exp 0/0", ovf_o, drop_cnt_o);
        end
    endtask

    task automatic test_fill_drain();
        test_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        checks++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 8'hA0) begin
            failures++; $display("FAIL full_head got v=%0b d=%h exp 1/a0", m_tvalid_o, m_tdata_o);
        end
        idle(4);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
        checks++;
        if (got != exp_q || m_tvalid_o !== 1'b0) begin
            failures++; $display("FAIL drain_seq got=%p v=%0b exp=%p v=0", got, m_tvalid_o, exp_q);
        end
    endtask

    task automatic test_full_push_pop();
        test_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hB4, 1'b1);
        checks++;
        if (m_tdata_o !== 8'hB1 || drop_cnt_o !== '0 || ovf_o !== 1'b0) begin
            failures++; $display("FAIL full_push_pop got d=%h cnt=%0d ovf=%0b exp b1/0/0", m_tdata_o, drop_cnt_o, ovf_o);
        end
        idle(5);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 8'hB0 + 8'(i)});
        checks++;
        if (got != exp_q) begin failures++; $display("FAIL full_push_pop_seq got=%p exp=%p", got, exp_q); end
    endtask

    task automatic test_drop_close();
        test_reset();
        for (int i = 0; i < 7; i++) step(1'b1, i == 6, 8'hC0 + 8'(i), 1'b0);
        checks++;
        if (drop_cnt_o !== 4'd3 || ovf_o !== 1'b1) begin
            failures++; $display("FAIL drop_count got cnt=%0d ovf=%0b exp 3/1", drop_cnt_o, ovf_o);
        end
        idle(6);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hC0 + 8'(i)});
        exp_q.push_back({1'b1, 8'hC6});
        checks++;
        if (got != exp_q) begin failures++; $display("FAIL close_seq got=%p exp=%p", got, exp_q); end
        // Back in pass mode: a new frame must flow straight through.
        got.delete();
        step(1'b1, 1'b1, 8'hCF, 1'b1);
        idle(1);
        checks++;
        if (got.size() != 1 || got[0] !== {1'b1, 8'hCF}) begin
            failures++; $display("FAIL after_close got=%p exp=[1cf]", got);
        end
    endtask

    task automatic test_close_refill();
        test_reset();
        for (int i = 0; i < 7; i++) step(1'b1, i == 6, 8'hC0 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'hD0, 1'b0);
        step(1'b1, 1'b1, 8'hD1, 1'b0);
        checks++;
        if (drop_cnt_o !== 4'd5) begin failures++; $display("FAIL close_refill_cnt got=%0d exp=5", drop_cnt_o); end
        idle(6);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hC0 + 8'(i)});
        exp_q.push_back({1'b1, 8'hD1});
        checks++;
        if (got != exp_q) begin failures++; $display("FAIL close_refill_seq got=%p exp=%p", got, exp_q); end
    endtask

    task automatic test_mid_reset();
        test_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        test_reset();
        step(1'b1, 1'b0, 8'hF0, 1'b1);
        step(1'b1, 1'b1, 8'hF1, 1'b1);
        idle(2);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hF0});
        exp_q.push_back({1'b1, 8'hF1});
        checks++;
        if (got != exp_q) begin failures++; $display("FAIL mid_reset_frame got=%p exp=%p", got, exp_q); end
    endtask

    task automatic test_saturation();
        test_reset();
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        checks++;
        if (drop_cnt_o !== 4'd15 || ovf_o !== 1'b1) begin
            failures++; $display("FAIL saturation got cnt=%0d ovf=%0b exp 15/1", drop_cnt_o, ovf_o);
        end
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                 8'($urandom), $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8));
        end
        idle(8);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough();
        test_fill_drain();
        test_full_push_pop();
        test_drop_close();
        test_close_refill();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
